alu_issue: RTL and testbench

Single-stage registered issue block that sits between instruction fetch/register read and `alu`. It decodes a 32-bit RV32I instruction plus its operands into the exact operand and `funct3`/`funct7` encoding `alu` consumes, and sanitises immediates and shift amounts so `alu` never sees an encoding it resolves to X. Transfers use a valid/ready handshake on both sides. Outputs are registered, so the block also serves as the decode/execute pipeline register.

---
 rtl/alu_issue_if.sv | 17 +
 rtl/alu_issue.sv | 89 ++++++++
 tb/tb_alu_issue.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream/downstream valid-ready bundle of the alu issue stage
interface alu_issue_if;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, pc, rs1_data, rs2_data, in1, in2;
  logic [2:0]  funct3, branch_cond;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic        rd_we, is_branch, illegal;
  modport master(
    output in_valid, inst, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, in1, in2, funct3, funct7, rd, rd_we, is_branch, branch_cond, illegal
  );
  modport slave(
    input  in_valid, inst, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, in1, in2, funct3, funct7, rd, rd_we, is_branch, branch_cond, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I into alu operands/funct fields and registers them as the decode/execute stage
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  alu_issue_if.slave  bus
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  logic [6:0]  opc, f7, d_f7;
  logic [2:0]  f3, d_f3;
  logic [31:0] i_imm, u_imm, d_in1, d_in2;
  logic        shift, cmp, d_legal, d_branch, accept;
  assign opc    = bus.inst[6:0];
  assign f3     = bus.inst[14:12];
  assign f7     = bus.inst[31:25];
  assign i_imm  = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign u_imm  = {bus.inst[31:12], 12'd0};
  assign shift  = f3 == 3'b001 || f3 == 3'b101;
  assign cmp    = f3 == 3'b010 || f3 == 3'b011;
  assign bus.in_ready = !flush && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    d_legal  = 1'b0;
    d_branch = 1'b0;
    d_in1    = bus.rs1_data;
    d_in2    = bus.rs2_data;
    d_f3     = f3;
    d_f7     = 7'd0;
    if (opc == OPC_OP) begin
      d_legal = !cmp && (f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      d_in2   = shift ? {27'd0, bus.rs2_data[4:0]} : bus.rs2_data;
      d_f7    = f7;
    end else if (opc == OPC_IMM) begin
      d_legal = !cmp && (f3 == 3'b001 ? f7 == 7'd0 :
                         f3 == 3'b101 ? (f7 == 7'd0 || f7 == 7'h20) : 1'b1);
      d_in2   = shift ? {27'd0, bus.inst[24:20]} : i_imm;
      d_f7    = f3 == 3'b101 ? f7 : 7'd0;
    end else if (opc == OPC_LUI || opc == OPC_AUIPC) begin
      d_legal = 1'b1;
      d_in1   = opc == OPC_AUIPC ? bus.pc : 32'd0;
      d_in2   = u_imm;
      d_f3    = 3'b000;
    end else if (opc == OPC_BR) begin
      d_legal  = !cmp;
      d_branch = 1'b1;
      d_f3     = 3'b000;
      d_f7     = 7'h20;
    end
    // illegal beats still issue, but carry a harmless all-zero ALU op
    if (!d_legal) begin
      d_in1    = 32'd0;
      d_in2    = 32'd0;
      d_f3     = 3'b000;
      d_f7     = 7'd0;
      d_branch = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.in1         <= '0;
      bus.in2         <= '0;
      bus.funct3      <= '0;
      bus.funct7      <= '0;
      bus.rd          <= '0;
      bus.rd_we       <= 1'b0;
      bus.is_branch   <= 1'b0;
      bus.branch_cond <= '0;
      bus.illegal     <= 1'b0;
    end else begin
      bus.out_valid <= flush ? 1'b0 : accept ? 1'b1 : bus.out_ready ? 1'b0 : bus.out_valid;
      if (accept) begin
        bus.in1         <= d_in1;
        bus.in2         <= d_in2;
        bus.funct3      <= d_f3;
        bus.funct7      <= d_f7;
        bus.rd          <= bus.inst[11:7];
        bus.rd_we       <= d_legal && !d_branch && bus.inst[11:7] != 5'd0;
        bus.is_branch   <= d_branch;
        bus.branch_cond <= d_branch ? f3 : 3'b000;
        bus.illegal     <= !d_legal;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven vectors with a scoreboard queue, plus backpressure/flush/reset sequences
module tb_alu_issue;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  alu_issue_if bus();
  alu_issue dut(.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] in1, in2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        we, br;
    logic [2:0]  bc;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [31:0] inst, pc, rs1, rs2;
    exp_t        e;
  } vec_t;
  localparam int N = 18;
  vec_t v[N];
  exp_t q[$];
  int checks = 0, errors = 0;
  function automatic vec_t mk(logic [31:0] inst, pc, rs1, rs2, in1, in2, logic [2:0] f3, logic [6:0] f7,
                              logic [4:0] rd, logic we, br, logic [2:0] bc, logic ill);
    vec_t r;
    r.inst = inst; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2;
    r.e = {in1, in2, f3, f7, rd, we, br, bc, ill};
    return r;
  endfunction
  function automatic exp_t got();
    return {bus.in1, bus.in2, bus.funct3, bus.funct7, bus.rd, bus.rd_we, bus.is_branch, bus.branch_cond, bus.illegal};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  task automatic step(input logic val, input vec_t x, input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid = val; bus.inst = x.inst; bus.pc = x.pc;
    bus.rs1_data = x.rs1; bus.rs2_data = x.rs2;
    bus.out_ready = ordy; flush = fl;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected beat: got %h want none", got());
      end else chk("beat", got(), q.pop_front());
    end
    if (bus.in_valid && bus.in_ready) q.push_back(x.e);
    if (fl) q.delete();
  endtask
  initial begin
    v[0]  = mk(32'h002081B3, 0, 5, 7, 5, 7, 3'b000, 7'h00, 3, 1, 0, 0, 0);
    v[1]  = mk(32'h40435293, 0, 32'h80000000, 32'h55, 32'h80000000, 4, 3'b101, 7'h20, 5, 1, 0, 0, 0);
    v[2]  = mk(32'hFFF00093, 0, 0, 32'h99, 0, 32'hFFFFFFFF, 3'b000, 7'h00, 1, 1, 0, 0, 0);
    v[3]  = mk(32'h00002013, 0, 32'h1234, 32'h5678, 0, 0, 3'b000, 7'h00, 0, 0, 0, 0, 1);
    v[4]  = mk(32'h02001013, 0, 32'h1234, 32'h5678, 0, 0, 3'b000, 7'h00, 0, 0, 0, 0, 1);
    v[5]  = mk(32'h00003393, 0, 32'h11, 32'h22, 0, 0, 3'b000, 7'h00, 7, 0, 0, 0, 1);
    v[6]  = mk(32'h00208463, 0, 9, 9, 9, 9, 3'b000, 7'h20, 8, 0, 1, 3'b000, 0);
    v[7]  = mk(32'h00002063, 0, 3, 4, 0, 0, 3'b000, 7'h00, 0, 0, 0, 0, 1);
    v[8]  = mk(32'h00209063, 0, 3, 4, 3, 4, 3'b000, 7'h20, 0, 0, 1, 3'b001, 0);
    v[9]  = mk(32'h12345537, 0, 32'hDEAD, 32'hBEEF, 0, 32'h12345000, 3'b000, 7'h00, 10, 1, 0, 0, 0);
    v[10] = mk(32'hFFFFF597, 32'h1000, 32'hDEAD, 32'hBEEF, 32'h1000, 32'hFFFFF000, 3'b000, 7'h00, 11, 1, 0, 0, 0);
    v[11] = mk(32'h40208233, 0, 10, 3, 10, 3, 3'b000, 7'h20, 4, 1, 0, 0, 0);
    v[12] = mk(32'h0020D333, 0, 32'hF0F0, 32'hFFFFFF25, 32'hF0F0, 5, 3'b101, 7'h00, 6, 1, 0, 0, 0);
    v[13] = mk(32'h40209233, 0, 10, 3, 0, 0, 3'b000, 7'h00, 4, 0, 0, 0, 1);
    v[14] = mk(32'h00208033, 0, 1, 2, 1, 2, 3'b000, 7'h00, 0, 0, 0, 0, 0);
    v[15] = mk(32'h00002083, 0, 8, 9, 0, 0, 3'b000, 7'h00, 1, 0, 0, 0, 1);
    v[16] = mk(32'h02035293, 0, 8, 9, 0, 0, 3'b000, 7'h00, 5, 0, 0, 0, 1);
    v[17] = mk(32'hFF00E113, 0, 32'h00FF, 9, 32'h00FF, 32'hFFFFFFF0, 3'b110, 7'h00, 2, 1, 0, 0, 0);
    bus.in_valid = 0; bus.out_ready = 0; bus.inst = 0; bus.pc = 0; bus.rs1_data = 0; bus.rs2_data = 0;
    #12;
    chk("reset outputs", got(), 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_ready", bus.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < N; i++) step(1, v[i], 1, 0);
    step(0, v[0], 1, 0);
    chk("stream drained", q.size(), 0);
    step(0, v[0], 1, 0);
    chk("idle out_valid", bus.out_valid, 0);
    step(1, v[0], 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, v[1], 0, 0);
      chk("bp in_ready", bus.in_ready, 0);
      chk("bp out_valid", bus.out_valid, 1);
      chk("bp hold", got(), v[0].e);
    end
    step(1, v[1], 1, 0);
    step(0, v[1], 1, 0);
    chk("no bubble", q.size(), 0);
    step(1, v[2], 0, 0);
    step(1, v[3], 0, 1);
    chk("flush in_ready", bus.in_ready, 0);
    chk("flush pre out_valid", bus.out_valid, 1);
    step(0, v[3], 1, 0);
    chk("flush clears", bus.out_valid, 0);
    step(1, v[9], 0, 0);
    step(0, v[9], 0, 0);
    chk("pre-reset out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", got(), 0);
    chk("async reset out_valid", bus.out_valid, 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    step(1, v[6], 1, 0);
    step(0, v[6], 1, 0);
    chk("post-reset drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
